// File: rtl/huffman_encoder.sv
// Fixed-table Huffman encoder: eight 4-bit symbols per 32-bit input word,
// one symbol per cycle, packed MSB-first into OUT_W-bit output words.
module huffman_encoder #(
  parameter int OUT_W = 8,
  parameter int NB_W  = $clog2(OUT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [NB_W-1:0]  out_nbits,
  output logic             sym_err,
  output logic             busy
);

  localparam int ACC_W = 2 * OUT_W;
  localparam int CW    = $clog2(ACC_W + 1);

  localparam logic [CW-1:0] OUT_W_C = CW'(OUT_W);
  localparam logic [CW:0]   ACC_W_C = (CW + 1)'(ACC_W);

  typedef enum logic [1:0] {IDLE, ENC, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic             last_q, last_d;
  logic [2:0]       sym_idx_q, sym_idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    acc_n_q, acc_n_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [NB_W-1:0]  out_nbits_q, out_nbits_d;
  logic             sym_err_q, sym_err_d;

  // Symbol lookup; codes are right-aligned in code, len bits long.
  logic [3:0] nib;
  logic [5:0] code;
  logic [2:0] len;
  logic       bad_sym;

  assign nib = word_q[31:28];

  // Code table lookup for the current nibble
  always_comb begin
    code    = 6'd0;
    len     = 3'd0;
    bad_sym = 1'b0;
    case (nib)
      4'd0:  begin code = 6'b000001; len = 3'd1; end
      4'd1:  begin code = 6'b000100; len = 3'd4; end
      4'd2:  begin code = 6'b000101; len = 3'd4; end
      4'd5:  begin code = 6'b000010; len = 3'd4; end
      4'd6:  begin code = 6'b000011; len = 3'd4; end
      4'd9:  begin code = 6'b000111; len = 3'd4; end
      4'd10: begin code = 6'b000000; len = 3'd4; end
      4'd7:  begin code = 6'b001101; len = 3'd5; end
      4'd3:  begin code = 6'b011000; len = 3'd6; end
      4'd4:  begin code = 6'b011001; len = 3'd6; end
      4'd8:  begin code = 6'b000110; len = 3'd6; end
      4'd12: begin code = 6'b000111; len = 3'd6; end
      4'd14: begin code = 6'b000100; len = 3'd6; end
      4'd15: begin code = 6'b000101; len = 3'd6; end
      default: bad_sym = 1'b1;   // 11 and 13 have no code
    endcase
  end

  logic             out_free;
  logic [CW-1:0]    drain_n;
  logic [CW-1:0]    avail;
  logic [CW:0]      fill;
  logic [CW:0]      sh;
  logic             fits;
  logic [ACC_W-1:0] code_ext;

  // Next-state, drain into the output register and append of the next code
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    last_d      = last_q;
    sym_idx_d   = sym_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_nbits_d = out_nbits_q;
    sym_err_d   = 1'b0;
    drain_n     = '0;

    out_free = !out_valid_q || out_ready;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (out_free) begin
      if (state_q == FLUSH && acc_n_q <= OUT_W_C) begin
        // Final word: whatever is left (possibly nothing), zero padded.
        out_data_d  = acc_q[ACC_W-1 -: OUT_W];
        out_nbits_d = acc_n_q[NB_W-1:0];
        out_last_d  = 1'b1;
        out_valid_d = 1'b1;
        drain_n     = acc_n_q;
        state_d     = IDLE;
      end else if (acc_n_q >= OUT_W_C) begin
        out_data_d  = acc_q[ACC_W-1 -: OUT_W];
        out_nbits_d = NB_W'(OUT_W);
        out_last_d  = 1'b0;
        out_valid_d = 1'b1;
        drain_n     = OUT_W_C;
      end
    end

    // Room check uses the post-drain fill so drain and append can share a cycle.
    avail    = acc_n_q - drain_n;
    fill     = {1'b0, avail} + {{(CW - 2){1'b0}}, len};
    fits     = (state_q == ENC) && (fill <= ACC_W_C);
    sh       = ACC_W_C - fill;
    code_ext = {{(ACC_W - 6){1'b0}}, code};

    acc_d   = acc_q << drain_n;
    acc_n_d = avail;
    if (fits) begin
      acc_d     = acc_d | (code_ext << sh);
      acc_n_d   = fill[CW-1:0];
      word_d    = word_q << 4;
      sym_idx_d = sym_idx_q + 3'd1;
      sym_err_d = bad_sym;
      if (sym_idx_q == 3'd7) state_d = last_q ? FLUSH : IDLE;
    end

    if (state_q == IDLE && in_valid) begin
      word_d    = in_data;
      last_d    = in_last;
      sym_idx_d = 3'd0;
      state_d   = ENC;
    end
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      last_q      <= 1'b0;
      sym_idx_q   <= '0;
      acc_q       <= '0;
      acc_n_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_nbits_q <= '0;
      sym_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      last_q      <= last_d;
      sym_idx_q   <= sym_idx_d;
      acc_q       <= acc_d;
      acc_n_q     <= acc_n_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_nbits_q <= out_nbits_d;
      sym_err_q   <= sym_err_d;
    end
  end

  assign in_ready  = rst && (state_q == IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_nbits = out_nbits_q;
  assign sym_err   = sym_err_q;
  assign busy      = (state_q != IDLE) || (acc_n_q != '0);

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed bench for huffman_encoder (OUT_W=8): table of single-word streams
// plus hand-written backpressure and mid-stream reset sequences.
module tb_huffman_encoder;

  localparam int OUT_W = 8;
  localparam int NB_W  = $clog2(OUT_W + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_last;
  logic [NB_W-1:0]  out_nbits;
  logic             sym_err;
  logic             busy;

  huffman_encoder #(.OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_nbits(out_nbits), .sym_err(sym_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    logic       last;
  } word_t;

  typedef struct {
    logic [31:0] din;
    int          nw;
    logic [7:0]  w [5];
    int          last_nb;
    int          nerr;
  } vec_t;

  word_t mon_q[$];
  vec_t  vecs[$];
  int    err_cnt  = 0;
  bit    got_last = 1'b0;
  int    n_chk    = 0;
  int    n_fail   = 0;

  // Inputs change at posedge+1, so a handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        mon_q.push_back('{data: out_data, nbits: int'(out_nbits), last: out_last});
        if (out_last) got_last = 1'b1;
      end
      if (sym_err) err_cnt++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] din, input int nw,
                     input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                     input logic [7:0] w3, input logic [7:0] w4,
                     input int last_nb, input int nerr);
    vec_t v;
    v.din = din; v.nw = nw;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
    v.last_nb = last_nb; v.nerr = nerr;
    vecs.push_back(v);
  endtask

  task automatic clear_mon();
    mon_q.delete();
    got_last = 1'b0;
    err_cnt  = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_data = d; in_last = l; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_last();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (got_last) break;
    end
    if (!got_last) chk("last_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  // Compare captured words against an expected stream; only the final word carries last.
  task automatic check_stream(input string tag, input vec_t v);
    chk({tag, "_nwords"}, mon_q.size(), v.nw);
    for (int i = 0; i < v.nw && i < mon_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), int'(mon_q[i].data), int'(v.w[i]));
      chk($sformatf("%s_last%0d", tag, i), int'(mon_q[i].last), (i == v.nw - 1) ? 1 : 0);
      chk($sformatf("%s_nbits%0d", tag, i), mon_q[i].nbits, (i == v.nw - 1) ? v.last_nb : OUT_W);
    end
    chk({tag, "_symerr"}, err_cnt, v.nerr);
  endtask

  initial begin
    vec_t v;
    logic [7:0] first;
    bit stable, seen;

    add(32'h0000_0000, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8, 0);
    add(32'h9999_9999, 4, 8'h77, 8'h77, 8'h77, 8'h77, 8'h00, 8, 0);
    add(32'h3000_0000, 2, 8'h63, 8'hF8, 8'h00, 8'h00, 8'h00, 5, 0);
    add(32'hB000_0000, 1, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 7, 1);
    add(32'hBBBB_BBBB, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8);
    add(32'h1234_5678, 5, 8'h45, 8'h61, 8'h92, 8'h36, 8'h8C, 7, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_sym_err", int'(sym_err), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Table of single-word streams
    for (int k = 0; k < vecs.size(); k++) begin
      clear_mon();
      send(vecs[k].din, 1'b1);
      wait_last();
      check_stream($sformatf("vec%0d", k), vecs[k]);
      chk($sformatf("vec%0d_idle", k), int'(busy), 0);
    end

    // Backpressure: first word stalls behind a full accumulator
    clear_mon();
    out_ready = 1'b0;
    send(32'h9999_9999, 1'b0);
    stable = 1'b1; seen = 1'b0; first = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (!seen) begin first = out_data; seen = 1'b1; end
        else if (out_data !== first) stable = 1'b0;
      end
    end
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_data", int'(out_data), 8'h77);
    chk("bp_stable", int'(stable), 1);
    chk("bp_busy", int'(busy), 1);
    chk("bp_stalled", int'(in_ready), 0);
    chk("bp_no_xfer", mon_q.size(), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h0000_0000, 1'b1);
    wait_last();
    v.din = '0; v.nw = 5;
    v.w[0] = 8'h77; v.w[1] = 8'h77; v.w[2] = 8'h77; v.w[3] = 8'h77; v.w[4] = 8'hFF;
    v.last_nb = 8; v.nerr = 0;
    check_stream("bp", v);

    // Reset mid-ENC: the aborted word must leave no trace
    clear_mon();
    send(32'h9999_9999, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    rst = 1'b1;
    send(32'h0000_0000, 1'b1);
    wait_last();
    v.din = '0; v.nw = 1;
    v.w[0] = 8'hFF; v.w[1] = 8'h00; v.w[2] = 8'h00; v.w[3] = 8'h00; v.w[4] = 8'h00;
    v.last_nb = 8; v.nerr = 0;
    check_stream("midrst", v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
